// File: rtl/r2mdc_stage_if.sv
// Bus for one radix-2 MDC stage: a sample pair with its twiddle and butterfly mode in,
// a reordered output pair with its valid flag out.
interface r2mdc_stage_if #(
   parameter int WIDTH = 23
);
   logic             en;
   logic             flush;
   logic             mode;
   logic [WIDTH-1:0] A_in;
   logic [WIDTH-1:0] B_in;
   logic [WIDTH-1:0] zeta;
   logic [WIDTH-1:0] A_out;
   logic [WIDTH-1:0] B_out;
   logic             valid;

   modport master (
      output en, flush, mode, A_in, B_in, zeta,
      input  A_out, B_out, valid
   );

   modport slave (
      input  en, flush, mode, A_in, B_in, zeta,
      output A_out, B_out, valid
   );
endinterface

// File: rtl/r2mdc_stage.sv
// One radix-2 multi-path delay commutator stage: a 3-cycle CT/GS modular butterfly
// followed by a delay commutator of distance DELAY (DELAY=0 bypasses the commutator).
module r2mdc_stage #(
   parameter int WIDTH = 23,
   parameter int Q     = 8380417,
   parameter int DELAY = 4
) (
   input  logic          clk,
   input  logic          reset,
   r2mdc_stage_if.slave  bus
);

   localparam int               PW        = 2 * WIDTH;
   localparam logic [WIDTH-1:0] QN        = WIDTH'(Q);
   localparam logic [WIDTH:0]   QW        = (WIDTH + 1)'(Q);
   localparam logic [PW-1:0]    QP        = PW'(Q);
   localparam logic [PW:0]      BARRETT_M = {1'b1, {PW{1'b0}}} / (PW + 1)'(Q);

   function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= QW)
         s = s - QW;
      return WIDTH'(s);
   endfunction

   function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (a >= b)
         return a - b;
      return a - b + QN;
   endfunction

   // Barrett estimate is at most two short of the true quotient, so two corrections suffice.
   function automatic logic [WIDTH-1:0] mod_reduce(input logic [PW-1:0] x);
      logic [2*PW:0] qx;
      logic [PW-1:0] q_est;
      logic [PW-1:0] r;
      qx    = {{(PW + 1){1'b0}}, x} * {{PW{1'b0}}, BARRETT_M};
      q_est = PW'(qx >> PW);
      r     = x - q_est * QP;
      if (r >= QP)
         r = r - QP;
      if (r >= QP)
         r = r - QP;
      return WIDTH'(r);
   endfunction

   logic             s1_v, s2_v, bf_v;
   logic             s1_mode, s2_mode;
   logic [WIDTH-1:0] s1_x, s1_y, s1_z;
   logic [WIDTH-1:0] s2_x, s2_t;
   logic [WIDTH-1:0] bf_a, bf_b;
   logic [PW-1:0]    s1_prod;

   assign s1_prod = {{WIDTH{1'b0}}, s1_y} * {{WIDTH{1'b0}}, s1_z};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         bf_v <= 1'b0;
      end else begin
         s1_v <= bus.en;
         s2_v <= s1_v;
         bf_v <= s2_v;
      end
   end

   // GS does its add/sub before the multiply and CT after, so both modes share the multiplier slot.
   always_ff @(posedge clk) begin
      s1_mode <= bus.mode;
      s1_x    <= bus.mode ? mod_add(bus.A_in, bus.B_in) : bus.A_in;
      s1_y    <= bus.mode ? mod_sub(bus.A_in, bus.B_in) : bus.B_in;
      s1_z    <= bus.zeta;
      s2_mode <= s1_mode;
      s2_x    <= s1_x;
      s2_t    <= mod_reduce(s1_prod);
      bf_a    <= s2_mode ? s2_x : mod_add(s2_x, s2_t);
      bf_b    <= s2_mode ? s2_t : mod_sub(s2_x, s2_t);
   end

   generate
      if (DELAY == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               bus.A_out <= '0;
               bus.B_out <= '0;
               bus.valid <= 1'b0;
            end else begin
               bus.A_out <= bf_a;
               bus.B_out <= bf_b;
               bus.valid <= bf_v;
            end
         end
      end else begin : g_comm
         localparam int CW = $clog2(2 * DELAY);

         logic [CW-1:0]      slot_cnt;
         logic               slot;
         logic [WIDTH-1:0]   a_line [DELAY];
         logic [WIDTH-1:0]   b_line [2*DELAY];
         logic [DELAY-1:0]   a_tag;
         logic [2*DELAY-1:0] b_tag;

         assign slot = bf_v | bus.flush;

         // Upper half of the frame pairs a-values D apart; lower half releases the b-values of the previous frame.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               slot_cnt  <= '0;
               a_tag     <= '0;
               b_tag     <= '0;
               bus.A_out <= '0;
               bus.B_out <= '0;
               bus.valid <= 1'b0;
            end else if (slot) begin
               slot_cnt <= slot_cnt + CW'(1);
               a_tag    <= (a_tag << 1) | DELAY'(bf_v);
               b_tag    <= (b_tag << 1) | (2 * DELAY)'(bf_v);
               if (slot_cnt[CW-1]) begin
                  bus.A_out <= a_line[DELAY-1];
                  bus.B_out <= bf_a;
                  bus.valid <= a_tag[DELAY-1] & bf_v;
               end else begin
                  bus.A_out <= b_line[2*DELAY-1];
                  bus.B_out <= b_line[DELAY-1];
                  bus.valid <= b_tag[2*DELAY-1] & b_tag[DELAY-1];
               end
            end else begin
               bus.valid <= 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (slot) begin
               a_line[0] <= bf_a;
               b_line[0] <= bf_b;
               for (int i = 1; i < DELAY; i++)
                  a_line[i] <= a_line[i-1];
               for (int i = 1; i < 2 * DELAY; i++)
                  b_line[i] <= b_line[i-1];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_r2mdc_stage.sv
// Bench for r2mdc_stage: D=2, D=4 and bypass stages share one stimulus stream and are each
// checked every cycle against a slot-indexed arithmetic model of butterfly plus commutator.
module tb_r2mdc_stage;

   localparam int WIDTH = 23;
   localparam int Q     = 8380417;

   logic             clk     = 1'b0;
   logic             reset   = 1'b1;
   logic             en      = 1'b0;
   logic             flush   = 1'b0;
   logic             mode    = 1'b0;
   logic [WIDTH-1:0] a_in    = '0;
   logic [WIDTH-1:0] b_in    = '0;
   logic [WIDTH-1:0] zeta_in = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   r2mdc_stage_if #(.WIDTH(WIDTH)) bus_d2 ();
   r2mdc_stage_if #(.WIDTH(WIDTH)) bus_d4 ();
   r2mdc_stage_if #(.WIDTH(WIDTH)) bus_d0 ();

   assign bus_d2.en = en;  assign bus_d2.flush = flush;  assign bus_d2.mode = mode;
   assign bus_d2.A_in = a_in;  assign bus_d2.B_in = b_in;  assign bus_d2.zeta = zeta_in;
   assign bus_d4.en = en;  assign bus_d4.flush = flush;  assign bus_d4.mode = mode;
   assign bus_d4.A_in = a_in;  assign bus_d4.B_in = b_in;  assign bus_d4.zeta = zeta_in;
   assign bus_d0.en = en;  assign bus_d0.flush = flush;  assign bus_d0.mode = mode;
   assign bus_d0.A_in = a_in;  assign bus_d0.B_in = b_in;  assign bus_d0.zeta = zeta_in;

   r2mdc_stage #(.WIDTH(WIDTH), .Q(Q), .DELAY(2)) u_d2 (.clk(clk), .reset(reset), .bus(bus_d2.slave));
   r2mdc_stage #(.WIDTH(WIDTH), .Q(Q), .DELAY(4)) u_d4 (.clk(clk), .reset(reset), .bus(bus_d4.slave));
   r2mdc_stage #(.WIDTH(WIDTH), .Q(Q), .DELAY(0)) u_d0 (.clk(clk), .reset(reset), .bus(bus_d0.slave));

   function automatic longint dly_of(input int k);
      case (k)
         0:       return 2;
         1:       return 4;
         default: return 0;
      endcase
   endfunction

   function automatic void butterfly(input longint a, input longint b, input longint z, input bit m,
                                     output longint ao, output longint bo);
      longint t;
      if (!m) begin
         t  = (b * z) % Q;
         ao = (a + t) % Q;
         bo = (a - t + Q) % Q;
      end else begin
         ao = (a + b) % Q;
         bo = (((a - b + Q) % Q) * z) % Q;
      end
   endfunction

   // Model state: the last four input samples, and every commutator slot indexed by its number since reset.
   bit     h_v [4];
   bit     h_m [4];
   longint h_a [4], h_b [4], h_z [4];
   longint slot_n [3];
   longint sa [3][4096];
   longint sb [3][4096];
   bit     st [3][4096];
   longint exp_a [3], exp_b [3];
   bit     exp_v [3];

   function automatic bit tag_at(input int k, input longint i);
      if (i < 0) return 1'b0;
      return st[k][i % 4096];
   endfunction

   function automatic longint a_at(input int k, input longint i);
      if (i < 0) return 0;
      return sa[k][i % 4096];
   endfunction

   function automatic longint b_at(input int k, input longint i);
      if (i < 0) return 0;
      return sb[k][i % 4096];
   endfunction

   always @(posedge clk) begin : model
      longint ba, bb, n, d, p;
      if (!reset) begin
         for (int i = 0; i < 4; i++) h_v[i] = 1'b0;
         for (int k = 0; k < 3; k++) begin
            slot_n[k] = 0; exp_a[k] = 0; exp_b[k] = 0; exp_v[k] = 1'b0;
         end
      end else begin
         for (int i = 3; i > 0; i--) begin
            h_v[i] = h_v[i-1]; h_m[i] = h_m[i-1];
            h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1]; h_z[i] = h_z[i-1];
         end
         h_v[0] = en; h_m[0] = mode; h_a[0] = a_in; h_b[0] = b_in; h_z[0] = zeta_in;
         ba = 0; bb = 0;
         if (h_v[3]) butterfly(h_a[3], h_b[3], h_z[3], h_m[3], ba, bb);
         for (int k = 0; k < 3; k++) begin
            d = dly_of(k);
            if (d == 0) begin
               exp_v[k] = h_v[3]; exp_a[k] = ba; exp_b[k] = bb;
            end else if (h_v[3] || flush) begin
               n = slot_n[k];
               sa[k][n % 4096] = ba; sb[k][n % 4096] = bb; st[k][n % 4096] = h_v[3];
               p = n % (2 * d);
               if (p >= d) begin
                  exp_a[k] = a_at(k, n - d);
                  exp_b[k] = ba;
                  exp_v[k] = tag_at(k, n - d) && h_v[3];
               end else begin
                  exp_a[k] = b_at(k, n - 2 * d);
                  exp_b[k] = b_at(k, n - d);
                  exp_v[k] = tag_at(k, n - 2 * d) && tag_at(k, n - d);
               end
               slot_n[k] = n + 1;
            end else begin
               exp_v[k] = 1'b0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   longint cap_a [3][$];
   longint cap_b [3][$];
   int     vcnt  [3];

   task automatic read_out(input int k, output longint oa, output longint ob, output bit ov);
      case (k)
         0:       begin oa = bus_d2.A_out; ob = bus_d2.B_out; ov = bus_d2.valid; end
         1:       begin oa = bus_d4.A_out; ob = bus_d4.B_out; ov = bus_d4.valid; end
         default: begin oa = bus_d0.A_out; ob = bus_d0.B_out; ov = bus_d0.valid; end
      endcase
   endtask

   // Outputs are compared on the falling edge, well clear of the registers updating.
   always @(negedge clk) begin : compare
      longint oa, ob;
      bit     ov;
      for (int k = 0; k < 3; k++) begin
         read_out(k, oa, ob, ov);
         if (!reset) begin
            checkOutput($sformatf("rst_valid_d%0d", dly_of(k)), longint'(ov), 0);
            checkOutput($sformatf("rst_a_d%0d", dly_of(k)), oa, 0);
            checkOutput($sformatf("rst_b_d%0d", dly_of(k)), ob, 0);
         end else begin
            checkOutput($sformatf("valid_d%0d", dly_of(k)), longint'(ov), longint'(exp_v[k]));
            if (exp_v[k]) begin
               checkOutput($sformatf("a_out_d%0d", dly_of(k)), oa, exp_a[k]);
               checkOutput($sformatf("b_out_d%0d", dly_of(k)), ob, exp_b[k]);
            end
            if (ov) begin
               cap_a[k].push_back(oa);
               cap_b[k].push_back(ob);
               vcnt[k]++;
            end
         end
      end
   end

   task automatic applyStimulus(input bit e, input bit f, input bit m,
                                input longint a, input longint b, input longint z);
      @(posedge clk);
      #1;
      en = e; flush = f; mode = m;
      a_in = WIDTH'(a); b_in = WIDTH'(b); zeta_in = WIDTH'(z);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic flush_cycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
   endtask

   task automatic clear_captures();
      for (int k = 0; k < 3; k++) begin
         cap_a[k].delete(); cap_b[k].delete(); vcnt[k] = 0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0; en = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      clear_captures();
   endtask

   longint ga [16], gb [16], gz [16];
   bit     gm [16];
   longint ref_a [$], ref_b [$];

   initial begin : stimulus
      longint ta, tb, e2a [4], e2b [4];
      int     g;
      #2 reset = 1'b0;
      do_reset();

      butterfly(Q - 1, 2, 1, 1'b0, ta, tb);
      checkOutput("model_ct_wrap_a", ta, 1);
      checkOutput("model_ct_wrap_b", tb, Q - 3);
      butterfly(0, 1, 2, 1'b1, ta, tb);
      checkOutput("model_gs_wrap_a", ta, 1);
      checkOutput("model_gs_wrap_b", tb, Q - 2);

      // CT with zeta=1 on D=2: a-pairs in the frame, then the same pairs again from the b-line.
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, i, 0, 1);
      idle(3);
      flush_cycles(2);
      idle(4);
      e2a = '{1, 2, 1, 2};
      e2b = '{3, 4, 3, 4};
      checkOutput("d2_frame_count", cap_a[0].size(), 4);
      if (cap_a[0].size() >= 4)
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("d2_frame_a%0d", i), cap_a[0][i], e2a[i]);
            checkOutput($sformatf("d2_frame_b%0d", i), cap_b[0][i], e2b[i]);
         end

      do_reset();
      applyStimulus(1'b1, 1'b0, 1'b0, Q - 1, 2, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 0, 1, 2);
      idle(6);
      checkOutput("wrap_count_d0", cap_a[2].size(), 2);
      if (cap_a[2].size() >= 2) begin
         checkOutput("wrap_ct_a", cap_a[2][0], 1);
         checkOutput("wrap_ct_b", cap_b[2][0], Q - 3);
         checkOutput("wrap_gs_a", cap_a[2][1], 1);
         checkOutput("wrap_gs_b", cap_b[2][1], Q - 2);
      end

      do_reset();
      for (int i = 0; i < 100; i++)
         applyStimulus(1'b1, 1'b0, 1'($urandom_range(1, 0)), $urandom_range(Q - 1, 0),
                       $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0));
      idle(6);
      checkOutput("bypass_count", vcnt[2], 100);

      // Same 16-sample stream contiguous and then with random gaps must emit the same D=4 sequence.
      for (int i = 0; i < 16; i++) begin
         ga[i] = $urandom_range(Q - 1, 0); gb[i] = $urandom_range(Q - 1, 0);
         gz[i] = $urandom_range(Q - 1, 0); gm[i] = 1'($urandom_range(1, 0));
      end
      do_reset();
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, gm[i], ga[i], gb[i], gz[i]);
      idle(3);
      flush_cycles(4);
      idle(4);
      checkOutput("contig_count_d4", vcnt[1], 16);
      ref_a = cap_a[1];
      ref_b = cap_b[1];
      do_reset();
      for (int i = 0; i < 16; i++) begin
         g = 0;
         while ($urandom_range(1, 0) == 1 && g < 8) begin
            idle(1);
            g++;
         end
         applyStimulus(1'b1, 1'b0, gm[i], ga[i], gb[i], gz[i]);
      end
      idle(3);
      flush_cycles(4);
      idle(4);
      checkOutput("gap_count_d4", vcnt[1], 16);
      checkOutput("gap_count_d2", vcnt[0], 16);
      if (cap_a[1].size() == ref_a.size())
         for (int i = 0; i < ref_a.size(); i++) begin
            checkOutput($sformatf("gap_seq_a%0d", i), cap_a[1][i], ref_a[i]);
            checkOutput($sformatf("gap_seq_b%0d", i), cap_b[1][i], ref_b[i]);
         end

      do_reset();
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0),
                       $urandom_range(Q - 1, 0));
      idle(2);
      checkOutput("midrst_pre_valid_d0", longint'(bus_d0.valid), 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("midrst_valid_d0", longint'(bus_d0.valid), 0);
      checkOutput("midrst_a_d0", longint'(bus_d0.A_out), 0);
      checkOutput("midrst_valid_d4", longint'(bus_d4.valid), 0);
      checkOutput("midrst_b_d4", longint'(bus_d4.B_out), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      clear_captures();
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 1'b0, 1'($urandom_range(1, 0)), $urandom_range(Q - 1, 0),
                       $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0));
      idle(3);
      flush_cycles(4);
      idle(4);
      checkOutput("midrst_new_count_d4", vcnt[1], 8);
      checkOutput("midrst_new_count_d2", vcnt[0], 8);

      // flush rides along with en once the butterfly is producing, then drains on its own.
      do_reset();
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, i >= 3, 1'($urandom_range(1, 0)), $urandom_range(Q - 1, 0),
                       $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0));
      flush_cycles(9);
      idle(4);
      checkOutput("enflush_count_d4", vcnt[1], 8);
      checkOutput("enflush_count_d2", vcnt[0], 8);
      checkOutput("enflush_count_d0", vcnt[2], 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
